druaga_hvgen: RTL and testbench

Video timing generator feeding the Druaga video top.
- Derives a 1-in-8 pixel clock enable from MCLK (49.125 MHz, giving a 6.14 MHz pixel rate).
- Runs H/V counters that drive the top's PH/PV inputs.
- Produces blanking and sync for the scan-converter/video output.
- Supports per-frame screen-centering offsets applied to the sync position.

---
 rtl/druaga_hvgen_pkg.sv | 20 ++
 rtl/druaga_hvgen_axis.sv | 73 +++++++
 rtl/druaga_hvgen.sv | 125 ++++++++++++
 tb/tb_druaga_hvgen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/druaga_hvgen_pkg.sv
// Shared video timing constants and counter type for the Druaga video path.
package druaga_video_pkg;

    localparam int unsigned H_TOTAL  = 384;
    localparam int unsigned H_VIS    = 288;
    localparam int unsigned HS_START = 312;
    localparam int unsigned HS_WIDTH = 32;
    localparam int unsigned V_TOTAL  = 264;
    localparam int unsigned V_VIS    = 224;
    localparam int unsigned VS_START = 240;
    localparam int unsigned VS_LINES = 3;

    typedef logic [8:0] cnt9_t;

    // Sign-extend a 4-bit screen offset to counter width.
    function automatic cnt9_t sext_ofs(input logic [3:0] ofs);
        return {{5{ofs[3]}}, ofs};
    endfunction

endpackage

// File: rtl/druaga_hvgen_axis.sv
// One timing axis: wrap counter with advance enable, blank compare and an
// offset-shifted sync window. Instantiated once for H and once for V.
module druaga_hvgen_axis
    import druaga_video_pkg::*;
#(
    parameter int unsigned TOTAL      = 384,
    parameter int unsigned VIS        = 288,
    parameter int unsigned SYNC_START = 312,
    parameter int unsigned SYNC_WIDTH = 32
) (
    input  logic  MCLK,
    input  logic  RESET,
    input  logic  adv,
    input  cnt9_t ofs,
    output cnt9_t cnt,
    output logic  wrap,
    output logic  blk,
    output logic  syn
);

    localparam cnt9_t LAST_C   = cnt9_t'(TOTAL - 1);
    localparam cnt9_t VIS_C    = cnt9_t'(VIS);
    localparam cnt9_t START_C  = cnt9_t'(SYNC_START);
    localparam cnt9_t WIDTH_M1 = cnt9_t'(SYNC_WIDTH - 1);

    cnt9_t cnt_q, cnt_d;
    logic  blk_q, blk_d;
    logic  syn_q, syn_d;
    cnt9_t cnt_nx_s;
    cnt9_t win_lo_s;
    cnt9_t win_hi_s;
    logic  wrap_s;

    // Next count, window bounds and registered blank/sync from the next count.
    always_comb begin
        wrap_s   = (cnt_q == LAST_C);
        cnt_nx_s = wrap_s ? 9'd0 : (cnt_q + 9'd1);
        // The windows never straddle the wrap point, so plain addition suffices.
        win_lo_s = START_C + ofs;
        win_hi_s = win_lo_s + WIDTH_M1;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        syn_d    = syn_q;
        if (adv) begin
            cnt_d = cnt_nx_s;
            blk_d = (cnt_nx_s >= VIS_C);
            syn_d = (cnt_nx_s >= win_lo_s) && (cnt_nx_s <= win_hi_s);
        end else begin
            cnt_d = cnt_q;
            blk_d = blk_q;
            syn_d = syn_q;
        end
    end

    // Axis state registers.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= 9'd0;
            blk_q <= 1'b0;
            syn_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
            syn_q <= syn_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_s;
    assign blk  = blk_q;
    assign syn  = syn_q;

endmodule

// File: rtl/druaga_hvgen.sv
// Druaga video timing generator: pixel enable, H/V counters, blank/sync, FRAME.
// Sync offsets are applied only when DRUAGA_HVGEN_OFFSET_EN is defined.
module druaga_hvgen
    import druaga_video_pkg::*;
#(
    parameter int unsigned H_TOTAL  = druaga_video_pkg::H_TOTAL,
    parameter int unsigned H_VIS    = druaga_video_pkg::H_VIS,
    parameter int unsigned HS_START = druaga_video_pkg::HS_START,
    parameter int unsigned HS_WIDTH = druaga_video_pkg::HS_WIDTH,
    parameter int unsigned V_TOTAL  = druaga_video_pkg::V_TOTAL,
    parameter int unsigned V_VIS    = druaga_video_pkg::V_VIS,
    parameter int unsigned VS_START = druaga_video_pkg::VS_START,
    parameter int unsigned VS_LINES = druaga_video_pkg::VS_LINES
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    output logic       PCE,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYN,
    output logic       VSYN,
    output logic       FRAME
);

    logic [2:0] div_q, div_d;
    logic       pce_q, pce_d;
    logic       frame_q, frame_d;
    cnt9_t      hofs_l_q, hofs_l_d;
    cnt9_t      vofs_l_q, vofs_l_d;

    logic       h_wrap_s;
    logic       v_wrap_s;
    logic       v_adv_s;
    logic       frame_end_s;

`ifndef DRUAGA_HVGEN_OFFSET_EN
    logic       unused_ofs_s;
    assign unused_ofs_s = ^{HOFS, VOFS};
`endif

    // Divider, pixel enable, frame toggle and offset latch next-state.
    always_comb begin
        div_d       = div_q + 3'd1;
        // PCE lands on the 8th MCLK after reset release and then every 8th.
        pce_d       = (div_q == 3'd7);
        v_adv_s     = pce_q && h_wrap_s;
        frame_end_s = v_adv_s && v_wrap_s;
        frame_d     = frame_q;
        hofs_l_d    = hofs_l_q;
        vofs_l_d    = vofs_l_q;
        if (frame_end_s) begin
            frame_d = ~frame_q;
`ifdef DRUAGA_HVGEN_OFFSET_EN
            hofs_l_d = sext_ofs(HOFS);
            vofs_l_d = sext_ofs(VOFS);
`else
            hofs_l_d = 9'd0;
            vofs_l_d = 9'd0;
`endif
        end else begin
            frame_d  = frame_q;
            hofs_l_d = hofs_l_q;
            vofs_l_d = vofs_l_q;
        end
    end

    // Top-level timing registers.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            div_q    <= 3'd0;
            pce_q    <= 1'b0;
            frame_q  <= 1'b0;
            hofs_l_q <= 9'd0;
            vofs_l_q <= 9'd0;
        end else begin
            div_q    <= div_d;
            pce_q    <= pce_d;
            frame_q  <= frame_d;
            hofs_l_q <= hofs_l_d;
            vofs_l_q <= vofs_l_d;
        end
    end

    // Axes see the offset that will hold after this edge, so a freshly
    // latched offset already governs the first pixel of the new frame.
    druaga_hvgen_axis #(
        .TOTAL      (H_TOTAL),
        .VIS        (H_VIS),
        .SYNC_START (HS_START),
        .SYNC_WIDTH (HS_WIDTH)
    ) u_h_axis (
        .MCLK  (MCLK),
        .RESET (RESET),
        .adv   (pce_q),
        .ofs   (hofs_l_d),
        .cnt   (PH),
        .wrap  (h_wrap_s),
        .blk   (HBLK),
        .syn   (HSYN)
    );

    druaga_hvgen_axis #(
        .TOTAL      (V_TOTAL),
        .VIS        (V_VIS),
        .SYNC_START (VS_START),
        .SYNC_WIDTH (VS_LINES)
    ) u_v_axis (
        .MCLK  (MCLK),
        .RESET (RESET),
        .adv   (v_adv_s),
        .ofs   (vofs_l_d),
        .cnt   (PV),
        .wrap  (v_wrap_s),
        .blk   (VBLK),
        .syn   (VSYN)
    );

    assign PCE   = pce_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_druaga_hvgen.sv
// Directed bench: a full-size instance checks divider and line timing, a
// shrunken-geometry instance checks whole frames, offsets and mid-frame reset.
module tb_druaga_hvgen;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] HOFS = 4'd0;
    logic [3:0] VOFS = 4'd0;

    logic       PCE_f, HBLK_f, VBLK_f, HSYN_f, VSYN_f, FRAME_f;
    logic [8:0] PH_f, PV_f;
    logic       PCE_s, HBLK_s, VBLK_s, HSYN_s, VSYN_s, FRAME_s;
    logic [8:0] PH_s, PV_s;

    int checks = 0;
    int failures = 0;

    // Small geometry: 64 x 20, visible 40 x 8, HSYNC 48..51, VSYNC 10..11.
    localparam int S_PIX = 64 * 20;
`ifdef DRUAGA_HVGEN_OFFSET_EN
    localparam int EXP_HS1_LO = 40;
    localparam int EXP_HS1_HI = 43;
    localparam int EXP_VS1_LO = 17;
    localparam int EXP_VS1_HI = 18;
`else
    localparam int EXP_HS1_LO = 48;
    localparam int EXP_HS1_HI = 51;
    localparam int EXP_VS1_LO = 10;
    localparam int EXP_VS1_HI = 11;
`endif

    always #5 MCLK = ~MCLK;

    druaga_hvgen dut_f (
        .MCLK(MCLK), .RESET(RESET), .HOFS(HOFS), .VOFS(VOFS),
        .PCE(PCE_f), .PH(PH_f), .PV(PV_f), .HBLK(HBLK_f), .VBLK(VBLK_f),
        .HSYN(HSYN_f), .VSYN(VSYN_f), .FRAME(FRAME_f)
    );

    druaga_hvgen #(
        .H_TOTAL(64), .H_VIS(40), .HS_START(48), .HS_WIDTH(4),
        .V_TOTAL(20), .V_VIS(8), .VS_START(10), .VS_LINES(2)
    ) dut_s (
        .MCLK(MCLK), .RESET(RESET), .HOFS(HOFS), .VOFS(VOFS),
        .PCE(PCE_s), .PH(PH_s), .PV(PV_s), .HBLK(HBLK_s), .VBLK(VBLK_s),
        .HSYN(HSYN_s), .VSYN(VSYN_s), .FRAME(FRAME_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Step edges until PCE is seen high; n = edges taken.
    task automatic wait_pce(output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(posedge MCLK);
            #1;
            n++;
            seen = PCE_f;
        end
        if (!seen) chk("pce_timeout", 0, 1);
    endtask

    // Move to the next pixel: through PCE and the advancing edge after it.
    task automatic next_px(output int n);
        wait_pce(n);
        @(posedge MCLK);
        #1;
        n++;
    endtask

    task automatic do_reset(input int hold);
        RESET = 1'b1;
        repeat (hold) @(posedge MCLK);
        @(negedge MCLK);
        RESET = 1'b0;
    endtask

    // Run one small-geometry frame from PH=0/PV=0, optionally changing the
    // offsets when PH=0 of line set_pv is reached.
    task automatic run_frame(input int set_pv, input logic [3:0] h, input logic [3:0] v,
                             output int hs_lo, output int hs_hi, output int vs_lo,
                             output int vs_hi, output int vb_lo, output int tog,
                             output int cyc, output int hb_err);
        int   n;
        logic prev;
        hs_lo = 999; hs_hi = -1; vs_lo = 999; vs_hi = -1; vb_lo = 999;
        tog = 0; cyc = 0; hb_err = 0;
        prev = FRAME_s;
        for (int p = 0; p < S_PIX; p++) begin
            if (HSYN_s) begin
                if (int'(PH_s) < hs_lo) hs_lo = int'(PH_s);
                if (int'(PH_s) > hs_hi) hs_hi = int'(PH_s);
            end
            if (VSYN_s) begin
                if (int'(PV_s) < vs_lo) vs_lo = int'(PV_s);
                if (int'(PV_s) > vs_hi) vs_hi = int'(PV_s);
            end
            if (VBLK_s && int'(PV_s) < vb_lo) vb_lo = int'(PV_s);
            if (HBLK_s != (PH_s >= 9'd40)) hb_err++;
            if (int'(PV_s) == set_pv && PH_s == 9'd0) begin
                HOFS = h;
                VOFS = v;
            end
            next_px(n);
            cyc += n;
            if (FRAME_s != prev) begin
                tog++;
                prev = FRAME_s;
            end
        end
    endtask

    initial begin
        int n, errs, hb_err, vb_err, hs_lo, hs_hi, vs_lo, vs_hi, vb_lo, tog, cyc;

        // ---- Reset state ----
        repeat (20) @(posedge MCLK);
        #1;
        chk("rst_flags_f", int'({PCE_f, HBLK_f, VBLK_f, HSYN_f, VSYN_f, FRAME_f}), 0);
        chk("rst_ph_f", int'(PH_f), 0);
        chk("rst_pv_f", int'(PV_f), 0);
        chk("rst_flags_s", int'({PCE_s, HBLK_s, VBLK_s, HSYN_s, VSYN_s, FRAME_s}), 0);
        @(negedge MCLK);
        RESET = 1'b0;

        // ---- Divider ----
        wait_pce(n);
        chk("first_pce_edges", n, 8);
        chk("ph_before_adv", int'(PH_f), 0);
        @(posedge MCLK);
        #1;
        chk("pce_one_cycle", int'(PCE_f), 0);
        chk("ph_first_adv", int'(PH_f), 1);
        wait_pce(n);
        chk("pce_spacing", n + 1, 8);
        @(posedge MCLK);
        #1;
        chk("ph_second_adv", int'(PH_f), 2);

        // ---- One full line on the spec-size instance ----
        errs = 0; hb_err = 0; vb_err = 0; hs_lo = 999; hs_hi = -1;
        for (int p = 2; p < 384; p++) begin
            if (int'(PH_f) != p) errs++;
            if (HBLK_f != (p >= 288)) hb_err++;
            if (VBLK_f) vb_err++;
            if (HSYN_f) begin
                if (p < hs_lo) hs_lo = p;
                if (p > hs_hi) hs_hi = p;
            end
            next_px(n);
        end
        chk("line_ph_seq", errs, 0);
        chk("line_hblk", hb_err, 0);
        chk("line_vblk", vb_err, 0);
        chk("line_hsyn_lo", hs_lo, 312);
        chk("line_hsyn_hi", hs_hi, 343);
        chk("wrap_ph", int'(PH_f), 0);
        chk("wrap_pv", int'(PV_f), 1);
        chk("wrap_hblk", int'(HBLK_f), 0);
        chk("wrap_hsyn", int'(HSYN_f), 0);

        // ---- Async reset mid-line ----
        for (int p = 0; p < 200; p++) next_px(n);
        chk("mid_ph", int'(PH_f), 200);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_ph", int'(PH_f), 0);
        chk("async_rst_pv", int'(PV_f), 0);

        // ---- Small-geometry frames and offsets ----
        HOFS = 4'd0;
        VOFS = 4'd0;
        do_reset(4);
        run_frame(5, 4'h8, 4'h7, hs_lo, hs_hi, vs_lo, vs_hi, vb_lo, tog, cyc, hb_err);
        chk("f0_hs_lo", hs_lo, 48);
        chk("f0_hs_hi", hs_hi, 51);
        chk("f0_vs_lo", vs_lo, 10);
        chk("f0_vs_hi", vs_hi, 11);
        chk("f0_vblk_lo", vb_lo, 8);
        chk("f0_hblk", hb_err, 0);
        chk("f0_frame_tog", tog, 1);
        chk("f0_end_pos", int'({PV_s, PH_s}), 0);
        chk("f0_frame_lvl", int'(FRAME_s), 1);

        run_frame(-1, 4'h8, 4'h7, hs_lo, hs_hi, vs_lo, vs_hi, vb_lo, tog, cyc, hb_err);
        chk("f1_hs_lo", hs_lo, EXP_HS1_LO);
        chk("f1_hs_hi", hs_hi, EXP_HS1_HI);
        chk("f1_vs_lo", vs_lo, EXP_VS1_LO);
        chk("f1_vs_hi", vs_hi, EXP_VS1_HI);
        chk("f1_frame_tog", tog, 1);
        chk("f1_cycles", cyc, S_PIX * 8);
        chk("f1_frame_lvl", int'(FRAME_s), 0);

        // ---- Mid-frame reset clears latched offsets ----
        for (int p = 0; p < 5 * 64 + 30; p++) next_px(n);
        chk("f2_mid_pv", int'(PV_s), 5);
        chk("f2_mid_ph", int'(PH_s), 30);
        #2 RESET = 1'b1;
        #1;
        chk("f2_rst_flags", int'({PCE_s, HBLK_s, VBLK_s, HSYN_s, VSYN_s, FRAME_s}), 0);
        chk("f2_rst_pos", int'({PV_s, PH_s}), 0);
        do_reset(3);
        run_frame(-1, 4'h8, 4'h7, hs_lo, hs_hi, vs_lo, vs_hi, vb_lo, tog, cyc, hb_err);
        chk("f3_hs_lo", hs_lo, 48);
        chk("f3_hs_hi", hs_hi, 51);
        chk("f3_vs_lo", vs_lo, 10);
        chk("f3_vs_hi", vs_hi, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
